// File: rtl/i2s_tx.sv
// I2S transmitter: 64-sclk stereo frames with 32-bit slots, one-bit data delay,
// and a one-entry holding buffer that feeds the next frame at each frame boundary.
module i2s_tx #(
  parameter int unsigned width_p         = 24,
  parameter int unsigned sclk_div_log2_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_left_i,
  input  logic [width_p-1:0] data_right_i,
  output logic               mclk_o,
  output logic               sclk_o,
  output logic               lrck_o,
  output logic               sdout_o,
  output logic               underflow_o
);

  localparam logic [sclk_div_log2_p-1:0] div_one = 1;

  logic [sclk_div_log2_p-1:0] div_r;
  logic [5:0]                 bit_cnt;
  logic                       hold_valid_r;
  logic [width_p-1:0]         hold_l_r;
  logic [width_p-1:0]         hold_r_r;
  logic [width_p-1:0]         frame_l_r;
  logic [width_p-1:0]         frame_r_r;
  logic                       underflow_r;

  logic                       div_wrap;
  logic                       frame_end;
  logic                       accept;
  logic [4:0]                 slot_bit;
  logic [width_p-1:0]         slot_data;
  logic [width_p-1:0]         slot_shift;

  always_comb begin
    div_wrap  = &div_r;
    frame_end = div_wrap & (&bit_cnt);
    ready_o   = ~hold_valid_r & ~reset_i;
    accept    = valid_i & ready_o;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_r        <= '0;
      bit_cnt      <= '0;
      hold_valid_r <= 1'b0;
      frame_l_r    <= '0;
      frame_r_r    <= '0;
      underflow_r  <= 1'b0;
    end else begin
      div_r       <= div_r + div_one;
      underflow_r <= frame_end & ~hold_valid_r;
      if (div_wrap)
        bit_cnt <= bit_cnt + 6'd1;
      // Boundary load uses the pre-edge hold contents; a coincident accept refills hold.
      if (frame_end) begin
        frame_l_r <= hold_valid_r ? hold_l_r : '0;
        frame_r_r <= hold_valid_r ? hold_r_r : '0;
      end
      if (accept) begin
        hold_valid_r <= 1'b1;
        hold_l_r     <= data_left_i;
        hold_r_r     <= data_right_i;
      end else if (frame_end) begin
        hold_valid_r <= 1'b0;
      end
    end
  end

  // Outputs decode registers that only change at the div_r wrap (sclk falling edge).
  // Shifting by (b-1) puts data bit width_p-b at the MSB; b > width_p shifts it all out.
  always_comb begin
    slot_bit    = bit_cnt[4:0];
    slot_data   = bit_cnt[5] ? frame_r_r : frame_l_r;
    slot_shift  = slot_data << (slot_bit - 5'd1);
    sdout_o     = (slot_bit != 5'd0) & slot_shift[width_p-1];
    mclk_o      = div_r[0];
    sclk_o      = div_r[sclk_div_log2_p-1];
    lrck_o      = bit_cnt[5];
    underflow_o = underflow_r;
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at default parameters: every output is checked each
// cycle against a frame-position model with hand-chosen frame contents.
module tb_i2s_tx;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_left_i = '0;
  logic [W-1:0] data_right_i = '0;
  logic         ready_o, mclk_o, sclk_o, lrck_o, sdout_o, underflow_o;

  int unsigned  n_tests = 0;
  int unsigned  n_fail = 0;
  logic [W-1:0] stream_val = 24'h000001;

  always #5 clk = ~clk;

  i2s_tx #(.width_p(W), .sclk_div_log2_p(3)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_left_i  (data_left_i),
    .data_right_i (data_right_i),
    .mclk_o       (mclk_o),
    .sclk_o       (sclk_o),
    .lrck_o       (lrck_o),
    .sdout_o      (sdout_o),
    .underflow_o  (underflow_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic check_reset_state(input string where);
    check({where, "/mclk"},      32'(mclk_o),      32'd0);
    check({where, "/sclk"},      32'(sclk_o),      32'd0);
    check({where, "/lrck"},      32'(lrck_o),      32'd0);
    check({where, "/sdout"},     32'(sdout_o),     32'd0);
    check({where, "/underflow"}, 32'(underflow_o), 32'd0);
    check({where, "/ready"},     32'(ready_o),     32'd1);
  endtask

  task automatic do_reset(input string where);
    reset_i = 1'b1;
    valid_i = 1'b0;
    repeat (3) tick;
    reset_i = 1'b0;
    #1;
    check_reset_state(where);
  endtask

  // mode: 0 = valid low, 1 = one-cycle offer at offer_at, 2 = valid held high with counting data
  task automatic run_frame(input logic [W-1:0] exp_l, input logic [W-1:0] exp_r,
                           input bit exp_uf, input int mode, input int unsigned offer_at,
                           input logic [W-1:0] off_l, input logic [W-1:0] off_r,
                           input int unsigned n_cyc);
    for (int unsigned pos = 0; pos < n_cyc; pos++) begin
      int unsigned  b;
      logic [W-1:0] ch;
      logic         exp_sd;
      b      = (pos / 8) % 32;
      ch     = (pos >= 256) ? exp_r : exp_l;
      exp_sd = 1'b0;
      if (b >= 1 && b <= W)
        exp_sd = ch[W-b];
      check("mclk",      32'(mclk_o),      32'(pos % 2));
      check("sclk",      32'(sclk_o),      32'((pos % 8) >= 4));
      check("lrck",      32'(lrck_o),      32'(pos >= 256));
      check("sdout",     32'(sdout_o),     32'(exp_sd));
      check("underflow", 32'(underflow_o), 32'(exp_uf && pos == 0));
      valid_i      = 1'b0;
      data_left_i  = 24'($urandom);
      data_right_i = 24'($urandom);
      case (mode)
        1: begin
          if (pos == offer_at) begin
            check("ready_offer", 32'(ready_o), 32'd1);
            valid_i      = 1'b1;
            data_left_i  = off_l;
            data_right_i = off_r;
          end else if (pos == offer_at + 1) begin
            check("ready_after_accept", 32'(ready_o), 32'd0);
          end
        end
        2: begin
          check("ready_stream", 32'(ready_o), 32'(pos == 0));
          valid_i      = 1'b1;
          data_left_i  = stream_val;
          data_right_i = ~stream_val;
        end
        default: ;
      endcase
      tick;
      if (mode == 2 && pos == 0)
        stream_val = stream_val + 24'd1;
    end
    valid_i = 1'b0;
  endtask

  initial begin
    // Reset release, idle: zero frame, then underflow at cycle 512
    do_reset("rst_release");
    run_frame('0, '0, 1'b0, 0, 0, '0, '0, 512);
    run_frame('0, '0, 1'b1, 0, 0, '0, '0, 512);

    // Single sample accepted at cycle 10 mid-frame; zero frame unaffected
    do_reset("rst_single");
    run_frame('0, '0, 1'b0, 1, 10, 24'hA5A5A5, 24'h5A5A5A, 512);
    run_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0, 0, 0, '0, '0, 512);

    // Streaming, with one idle frame producing an underflow, then resuming
    run_frame('0, '0, 1'b1, 2, 0, '0, '0, 512);
    run_frame(24'h000001, 24'hFFFFFE, 1'b0, 2, 0, '0, '0, 512);
    run_frame(24'h000002, 24'hFFFFFD, 1'b0, 0, 0, '0, '0, 512);
    run_frame('0, '0, 1'b1, 2, 0, '0, '0, 512);

    // Accept in the boundary cycle: underflow now, sample in the frame after
    run_frame(24'h000003, 24'hFFFFFC, 1'b0, 1, 511, 24'hC3C3C3, 24'h3C3C3C, 512);
    check("ready_after_coincident", 32'(ready_o), 32'd0);
    run_frame('0, '0, 1'b1, 0, 0, '0, '0, 512);

    // Mid-frame reset at bit_cnt 40 with the holding buffer full
    run_frame(24'hC3C3C3, 24'h3C3C3C, 1'b0, 1, 5, 24'h111111, 24'h222222, 320);
    check("ready_before_reset", 32'(ready_o), 32'd0);
    reset_i = 1'b1;
    #1;
    check("ready_during_reset", 32'(ready_o), 32'd0);
    tick;
    reset_i = 1'b0;
    #1;
    check_reset_state("rst_midframe");
    run_frame('0, '0, 1'b0, 0, 0, '0, '0, 512);
    run_frame('0, '0, 1'b1, 0, 0, '0, '0, 512);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter width_p, default 24, giving the sample bits per channel; legal range 1..31.
REQ-002 SHALL have parameter sclk_div_log2_p, default 3, giving log2 of the clk_i cycles per sclk_o period; minimum 2.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_i  input  1  a stereo sample is offered.
REQ-006 SHALL have port ready_o  output  1  the block can accept a sample.
REQ-007 SHALL have port data_left_i  input  width_p  left sample, two's complement.
REQ-008 SHALL have port data_right_i  input  width_p  right sample, two's complement.
REQ-009 SHALL have port mclk_o  output  1  main clock, clk_i/2.
REQ-010 SHALL have port sclk_o  output  1  serial bit clock.
REQ-011 SHALL have port lrck_o  output  1  channel select; 0 = left, 1 = right.
REQ-012 SHALL have port sdout_o  output  1  serial data.
REQ-013 SHALL have port underflow_o  output  1  one-cycle pulse when a frame starts with no sample buffered.

Function
REQ-014 SHALL keep a free-running counter div_r of sclk_div_log2_p bits, incrementing every cycle and wrapping.
- mclk_o = div_r[0].
- sclk_o = div_r[MSB].
REQ-015 SHALL keep a 6-bit bit counter bit_cnt, incremented in the cycle where div_r wraps from all-ones to 0 (the sclk_o falling edge).
- One frame is 64 sclk periods, i.e. 64 * 2^sclk_div_log2_p clk_i cycles (512 at default).
REQ-016 SHALL drive lrck_o = bit_cnt[5], giving 32-bit left and right slots.
REQ-017 SHALL drive sdout_o from the slot bit index b = bit_cnt[4:0] as follows:
- b = 0: 0 (I2S one-bit delay).
- b = 1..width_p: channel data, MSB first.
- b > width_p: 0.
REQ-018 SHALL change sdout_o and lrck_o only on sclk_o falling edges, so both are stable at every sclk_o rising edge.
REQ-019 SHALL provide a one-entry holding buffer (hold_valid_r, hold_l_r, hold_r_r) with ready_o = ~hold_valid_r, forced to 0 while reset_i is high.
REQ-020 SHALL accept a sample when valid_i & ready_o are both high at a clock edge.
- The accepted sample is written to the holding buffer.
- ready_o drops in the following cycle.
REQ-021 SHALL handle the frame boundary (bit_cnt 63->0 at the div_r wrap) as follows:
- If hold_valid_r = 1: copy the holding buffer into the frame registers and clear hold_valid_r.
- If hold_valid_r = 0: load zeros into the frame registers and pulse underflow_o high for exactly that one cycle.
REQ-022 SHALL evaluate the frame-boundary load against hold contents from before the edge when an accept coincides with the boundary.
- The new sample is held for the next frame.
- underflow_o pulses, since hold was empty.
REQ-023 SHALL hold the frame registers constant for the whole frame; a new accept mid-frame SHALL NOT alter the bits being transmitted.
REQ-024 SHALL ignore data inputs whenever valid_i is low, and SHALL NOT require valid_i to stay asserted once asserted.

Reset
REQ-025 SHALL, on a clock edge with reset_i high, clear the following state:
- div_r = 0, bit_cnt = 0.
- hold_valid_r = 0.
- frame registers = 0.
REQ-026 SHALL give these output values in the cycle after a reset edge:
- mclk_o = 0, sclk_o = 0, lrck_o = 0.
- sdout_o = 0, underflow_o = 0.
- ready_o = 1, provided reset_i is low.
REQ-027 SHALL discard a buffered sample and the in-progress frame on a reset asserted mid-frame.
REQ-028 SHALL transmit an all-zero frame as the first frame after reset; the first possible sample load is the first frame boundary, 512 cycles after reset at default parameters.

Verification (default parameters)
REQ-029 SHALL be checked with a reset-release scenario: deassert reset_i and idle.
- mclk_o toggles every cycle.
- sclk_o first rises 4 cycles after release, period 8.
- lrck_o toggles every 256 cycles.
- underflow_o pulses at cycle 512.
REQ-030 SHALL be checked with a single-sample scenario: accept L=0xA5A5A5, R=0x5A5A5A at cycle 10.
- Frame starting at cycle 512, sampled on sclk_o rising edges: left slot bit 0 = 0, bits 1..24 = 0xA5A5A5 MSB first, bits 25..31 = 0.
- Right slot gives 0x5A5A5A in the same positions.
- No underflow pulse at 512.
REQ-031 SHALL be checked with a streaming scenario: valid_i held high with incrementing data.
- One accept per 512 cycles.
- ready_o reasserts the cycle after each boundary.
- Frames carry consecutive values.
- No underflow after the first boundary.
REQ-032 SHALL be checked with an underflow scenario: no valid_i for one frame.
- underflow_o is high for exactly 1 cycle at the boundary.
- sdout_o = 0 for all 64 bits.
- Streaming resumes correctly afterwards.
REQ-033 SHALL be checked with a coincident-accept scenario: accept exactly in the boundary cycle.
- underflow_o pulses.
- The sample appears in the following frame.
REQ-034 SHALL be checked with a mid-frame reset scenario: assert reset_i at bit_cnt = 40 with the holding buffer full.
- Next cycle, all outputs equal the REQ-026 values.
- The held sample is never transmitted.
